// File: rtl/serial_parity_unit.sv
// Serial parity engine: generates a parity bit over FRAME_LEN data bits, or checks
// a received parity bit after FRAME_LEN data bits and keeps a saturating error count.
module serial_parity_unit #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 frame_clr,
  input  logic                 odd_mode,
  input  logic                 check_mode,
  output logic                 parity_out,
  output logic                 parity_valid,
  output logic                 frame_done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [CNT_W-1:0]     bit_count
);

  typedef enum logic {
    DATA = 1'b0,
    PAR  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_LEN);

  state_t                 state, state_n;
  logic                   acc, acc_n;
  logic                   odd_lat, odd_lat_n;
  logic                   chk_lat, chk_lat_n;
  logic                   parity_out_n, parity_valid_n, frame_done_n, err_n;
  logic [ERR_CNT_W-1:0]   err_count_n;
  logic [CNT_W-1:0]       bit_count_n;

  logic first_bit, last_bit, eff_odd, eff_chk, acc_sum, mismatch, err_sat;

  // Mode is taken live on the first bit of a frame, from the latch afterwards.
  assign first_bit = (bit_count == '0);
  assign last_bit  = (bit_count == LAST_IDX);
  assign eff_odd   = first_bit ? odd_mode   : odd_lat;
  assign eff_chk   = first_bit ? check_mode : chk_lat;
  assign acc_sum   = acc ^ bit_in;
  assign mismatch  = acc ^ bit_in ^ odd_lat;
  assign err_sat   = &err_count;

  // Next-state and output logic.
  always_comb begin
    state_n        = state;
    acc_n          = acc;
    odd_lat_n      = odd_lat;
    chk_lat_n      = chk_lat;
    bit_count_n    = bit_count;
    parity_out_n   = parity_out;
    err_n          = err;
    err_count_n    = err_count;
    parity_valid_n = 1'b0;
    frame_done_n   = 1'b0;

    if (frame_clr) begin
      state_n     = DATA;
      acc_n       = 1'b0;
      bit_count_n = '0;
    end else if (bit_valid) begin
      unique case (state)
        DATA: begin
          if (first_bit) begin
            odd_lat_n = odd_mode;
            chk_lat_n = check_mode;
          end
          if (last_bit) begin
            if (eff_chk) begin
              state_n     = PAR;
              acc_n       = acc_sum;
              bit_count_n = FULL_CNT;
            end else begin
              parity_out_n   = acc_sum ^ eff_odd;
              parity_valid_n = 1'b1;
              frame_done_n   = 1'b1;
              acc_n          = 1'b0;
              bit_count_n    = '0;
            end
          end else begin
            acc_n       = acc_sum;
            bit_count_n = bit_count + CNT_W'(1);
          end
        end
        PAR: begin
          err_n        = mismatch;
          frame_done_n = 1'b1;
          if (mismatch && !err_sat) begin
            err_count_n = err_count + ERR_CNT_W'(1);
          end
          acc_n       = 1'b0;
          bit_count_n = '0;
          state_n     = DATA;
        end
        default: state_n = DATA;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DATA;
      acc          <= 1'b0;
      odd_lat      <= 1'b0;
      chk_lat      <= 1'b0;
      bit_count    <= '0;
      parity_out   <= 1'b0;
      parity_valid <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_n;
      acc          <= acc_n;
      odd_lat      <= odd_lat_n;
      chk_lat      <= chk_lat_n;
      bit_count    <= bit_count_n;
      parity_out   <= parity_out_n;
      parity_valid <= parity_valid_n;
      frame_done   <= frame_done_n;
      err          <= err_n;
      err_count    <= err_count_n;
    end
  end

endmodule

// File: tb/tb_serial_parity_unit.sv
// Directed bench for serial_parity_unit: expected frame results are queued when the
// closing bit is driven and compared when the frame_done/parity_valid pulse appears.
module tb_serial_parity_unit;

  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned ERR_CNT_W = 2;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

  logic                 clk;
  logic                 reset;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 frame_clr;
  logic                 odd_mode;
  logic                 check_mode;
  logic                 parity_out;
  logic                 parity_valid;
  logic                 frame_done;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;
  logic [CNT_W-1:0]     bit_count;

  typedef struct packed {
    logic                 pv;
    logic                 po;
    logic                 er;
    logic [ERR_CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic                 m_par = 1'b0;
  logic                 m_err = 1'b0;
  logic [ERR_CNT_W-1:0] m_cnt = '0;
  logic                 m_acc = 1'b0;
  logic                 m_odd = 1'b0;

  serial_parity_unit #(
    .FRAME_LEN(FRAME_LEN),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .frame_clr(frame_clr),
    .odd_mode(odd_mode),
    .check_mode(check_mode),
    .parity_out(parity_out),
    .parity_valid(parity_valid),
    .frame_done(frame_done),
    .err(err),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic c, input logic o, input logic m);
    @(negedge clk);
    bit_valid  = v;
    bit_in     = b;
    frame_clr  = c;
    odd_mode   = o;
    check_mode = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Data bits MSB first; a generate frame queues its result on the last bit.
  task automatic send_data(input logic [7:0] d, input logic odd, input logic chk_m, input int gap);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, d[i], 1'b0, odd, chk_m);
      if (i == 0 && !chk_m) begin
        m_par = ^d ^ odd;
        e = '{pv: 1'b1, po: m_par, er: m_err, cnt: m_cnt};
        sb.push_back(e);
      end
      if (i != 0) begin
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0, ~odd, ~chk_m);
      end
    end
    m_acc = ^d;
    m_odd = odd;
  endtask

  task automatic send_par(input logic p);
    exp_t e;
    logic mis;
    drive(1'b1, p, 1'b0, 1'b0, 1'b0);
    mis   = m_acc ^ p ^ m_odd;
    m_err = mis;
    if (mis && (m_cnt != '1)) m_cnt = m_cnt + ERR_CNT_W'(1);
    e = '{pv: 1'b0, po: m_par, er: m_err, cnt: m_cnt};
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_par = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
    m_acc = 1'b0;
    m_odd = 1'b0;
  endtask

  // Scoreboard pop on every result pulse; a pulse with nothing queued is a failure.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && (frame_done === 1'b1 || parity_valid === 1'b1)) begin
      chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("parity_valid", 32'(parity_valid), 32'(e.pv));
        chk("parity_out", 32'(parity_out), 32'(e.po));
        chk("err", 32'(err), 32'(e.er));
        chk("err_count", 32'(err_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    frame_clr = 1'b0;
    odd_mode = 1'b0;
    check_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_parity_out", 32'(parity_out), 32'd0);
    chk("rst_parity_valid", 32'(parity_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_bit_count", 32'(bit_count), 32'd0);
    reset = 1'b0;

    // Generate even, contiguous 0xA5
    send_data(8'hA5, 1'b0, 1'b0, 0);
    idle(1);
    chk("gen_even_bit_count", 32'(bit_count), 32'd0);
    chk("gen_even_pv_pulse", 32'(parity_valid), 32'd1);
    idle(1);
    chk("gen_even_pv_one_cycle", 32'(parity_valid), 32'd0);
    chk("gen_even_fd_one_cycle", 32'(frame_done), 32'd0);

    // Generate odd with idle gaps (modes toggled during gaps must be ignored)
    send_data(8'hA5, 1'b1, 1'b0, 1);
    idle(2);
    chk("gen_odd_parity_hold", 32'(parity_out), 32'd1);

    // Check even 0x07: good parity then bad parity
    send_data(8'h07, 1'b0, 1'b1, 0);
    idle(1);
    chk("chk_par_bit_count", 32'(bit_count), 32'd8);
    send_par(1'b1);
    idle(2);
    send_data(8'h07, 1'b0, 1'b1, 2);
    send_par(1'b0);
    idle(3);
    chk("chk_err_held", 32'(err), 32'd1);

    // Mode toggles after bit 3: mode sampled at bit 1 (even) wins
    begin
      logic [7:0] d;
      exp_t e;
      d = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
        drive(1'b1, d[i], 1'b0, (i < 5), 1'b0);
        if (i == 0) begin
          m_par = ^d;
          e = '{pv: 1'b1, po: m_par, er: m_err, cnt: m_cnt};
          sb.push_back(e);
        end
      end
      idle(2);
    end

    // Abort after 5 bits, then a full 0xFF even frame
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("clr_partial_count", 32'(bit_count), 32'd5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("clr_bit_count", 32'(bit_count), 32'd0);
    chk("clr_err_retained", 32'(err), 32'd1);
    chk("clr_cnt_retained", 32'(err_count), 32'd1);
    send_data(8'hFF, 1'b0, 1'b0, 0);
    idle(2);

    // Back-to-back generate frames
    send_data(8'h01, 1'b0, 1'b0, 0);
    send_data(8'h03, 1'b1, 1'b0, 0);
    idle(2);

    // Reset while waiting for the parity bit
    send_data(8'h0F, 1'b1, 1'b1, 0);
    @(negedge clk);
    bit_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstpar_bit_count", 32'(bit_count), 32'd0);
    chk("rstpar_err", 32'(err), 32'd0);
    chk("rstpar_err_count", 32'(err_count), 32'd0);
    chk("rstpar_parity_out", 32'(parity_out), 32'd0);
    reset = 1'b0;
    model_reset();
    send_data(8'h0F, 1'b1, 1'b1, 0);
    send_par(1'b1);
    idle(2);

    // Saturation: five bad frames with a 2-bit counter
    for (int f = 0; f < 5; f++) begin
      send_data(8'h07, 1'b0, 1'b1, 0);
      send_par(1'b0);
      idle(2);
      chk("sat_err_after_frame", 32'(err), 32'd1);
    end
    chk("sat_final_count", 32'(err_count), 32'd3);

    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
